// File: rtl/hdmi_video_timing.sv
// Video timing generator for an HDMI 4:2:2 output path: raster counters, sync/DE
// generation and pixel fetch from a first-word-fall-through source, with registered outputs.
module hdmi_video_timing #(
  parameter int H_ACTIVE = 1280,
  parameter int H_FP     = 110,
  parameter int H_SYNC   = 40,
  parameter int H_BP     = 220,
  parameter int V_ACTIVE = 720,
  parameter int V_FP     = 5,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 20,
  parameter int HS_POL   = 1,
  parameter int VS_POL   = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [7:0] pix_y,
  input  logic [7:0] pix_cb,
  input  logic [7:0] pix_cr,
  input  logic       pix_valid,
  output logic       pix_req,
  output logic [7:0] y,
  output logic [7:0] c,
  output logic       hsync_out,
  output logic       vsync_out,
  output logic       de_out,
  output logic       frame_start,
  output logic       underflow,
  input  logic       clr_underflow
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
  localparam int VW = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;
  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam int H_SS = H_ACTIVE + H_FP;
  localparam int V_SS = V_ACTIVE + V_FP;
  localparam logic HS_ON = (HS_POL != 0);
  localparam logic VS_ON = (VS_POL != 0);
  localparam logic [7:0] BLACK_Y = 8'h10;
  localparam logic [7:0] BLACK_C = 8'h80;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t          state_r, state_s;
  logic [HW-1:0]   h_cnt_r, h_cnt_s, h_next_s;
  logic [VW-1:0]   v_cnt_r, v_cnt_s, v_next_s;
  logic            h_wrap_s, v_wrap_s;
  logic            running_s, act_s, hs_reg_s, vs_reg_s, origin_s;

  // Raster position decode shared by the FSM and the output stage.
  always_comb begin
    h_wrap_s  = (h_cnt_r == H_LAST);
    v_wrap_s  = (v_cnt_r == V_LAST);
    h_next_s  = h_wrap_s ? {HW{1'b0}} : (h_cnt_r + HW'(1));
    v_next_s  = v_cnt_r;
    if (h_wrap_s) begin
      v_next_s = v_wrap_s ? {VW{1'b0}} : (v_cnt_r + VW'(1));
    end else begin
      v_next_s = v_cnt_r;
    end
    running_s = (state_r == ST_RUN) || (state_r == ST_DRAIN);
    act_s     = running_s && (int'(h_cnt_r) < H_ACTIVE) && (int'(v_cnt_r) < V_ACTIVE);
    hs_reg_s  = running_s && (int'(h_cnt_r) >= H_SS) && (int'(h_cnt_r) < H_SS + H_SYNC);
    vs_reg_s  = running_s && (int'(v_cnt_r) >= V_SS) && (int'(v_cnt_r) < V_SS + V_SYNC);
    origin_s  = running_s && (h_cnt_r == {HW{1'b0}}) && (v_cnt_r == {VW{1'b0}});
  end

  assign pix_req = act_s;

  // Next-state and counter update; DRAIN only returns to IDLE on the frame's last pixel.
  always_comb begin
    state_s = state_r;
    h_cnt_s = h_cnt_r;
    v_cnt_s = v_cnt_r;
    case (state_r)
      ST_IDLE: begin
        h_cnt_s = {HW{1'b0}};
        v_cnt_s = {VW{1'b0}};
        if (enable) state_s = ST_RUN;
        else        state_s = ST_IDLE;
      end
      ST_RUN: begin
        h_cnt_s = h_next_s;
        v_cnt_s = v_next_s;
        if (enable) state_s = ST_RUN;
        else        state_s = ST_DRAIN;
      end
      ST_DRAIN: begin
        h_cnt_s = h_next_s;
        v_cnt_s = v_next_s;
        if (enable)                    state_s = ST_RUN;
        else if (h_wrap_s && v_wrap_s) state_s = ST_IDLE;
        else                           state_s = ST_DRAIN;
      end
      default: begin
        state_s = ST_IDLE;
        h_cnt_s = {HW{1'b0}};
        v_cnt_s = {VW{1'b0}};
      end
    endcase
  end

  // State and raster counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      h_cnt_r <= {HW{1'b0}};
      v_cnt_r <= {VW{1'b0}};
    end else begin
      state_r <= state_s;
      h_cnt_r <= h_cnt_s;
      v_cnt_r <= v_cnt_s;
    end
  end

  // Registered video outputs, one clock behind the counter state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      de_out      <= 1'b0;
      hsync_out   <= ~HS_ON;
      vsync_out   <= ~VS_ON;
      y           <= BLACK_Y;
      c           <= BLACK_C;
      frame_start <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      de_out      <= act_s;
      hsync_out   <= hs_reg_s ? HS_ON : ~HS_ON;
      vsync_out   <= vs_reg_s ? VS_ON : ~VS_ON;
      frame_start <= origin_s;
      if (act_s && pix_valid) begin
        y <= pix_y;
        c <= h_cnt_r[0] ? pix_cr : pix_cb;
      end else begin
        y <= BLACK_Y;
        c <= BLACK_C;
      end
      // A starved active pixel outranks a simultaneous clear.
      if (act_s && !pix_valid) underflow <= 1'b1;
      else if (clr_underflow)  underflow <= 1'b0;
      else                     underflow <= underflow;
    end
  end

endmodule

// File: tb/tb_hdmi_video_timing.sv
// Directed bench for hdmi_video_timing on a 16x8 raster: a vector table covering two
// frames with underflow events, plus hand sequences for mid-frame reset and drain/re-enable.
module tb_hdmi_video_timing;

  localparam int HA = 8, HF = 2, HS = 3, HB = 3;
  localparam int VA = 4, VF = 1, VS = 2, VB = 1;
  localparam int HT = 16, VT = 8;
  localparam int NV = 262;

  typedef struct {
    logic       en;
    logic       valid;
    logic       clr;
    logic [7:0] py;
    logic       e_req;
    logic       e_de;
    logic       e_hs;
    logic       e_vs;
    logic       e_fs;
    logic       e_uf;
    logic [7:0] e_y;
    logic [7:0] e_c;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n, enable, pix_valid, clr_underflow;
  logic [7:0] pix_y, pix_cb, pix_cr, y, c;
  logic       pix_req, hsync_out, vsync_out, de_out, frame_start, underflow;
  int         checks = 0;
  int         errors = 0;
  vec_t       tbl [NV];

  always #5 clk = ~clk;

  hdmi_video_timing #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HS_POL(1), .VS_POL(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .pix_y(pix_y), .pix_cb(pix_cb), .pix_cr(pix_cr), .pix_valid(pix_valid),
    .pix_req(pix_req), .y(y), .c(c),
    .hsync_out(hsync_out), .vsync_out(vsync_out), .de_out(de_out),
    .frame_start(frame_start), .underflow(underflow), .clr_underflow(clr_underflow)
  );

  task automatic chk8(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %02h expected %02h", name, $time, got, exp);
    end
  endtask

  task automatic chk1(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %b expected %b", name, $time, got, exp);
    end
  endtask

  function automatic logic act_at(input int p);
    int h, v;
    h = p % HT;
    v = (p / HT) % VT;
    return (h < HA) && (v < VA);
  endfunction

  function automatic logic hs_at(input int p);
    int h;
    h = p % HT;
    return (h >= HA + HF) && (h < HA + HF + HS);
  endfunction

  function automatic logic vs_at(input int p);
    int v;
    v = (p / HT) % VT;
    return (v >= VA + VF) && (v < VA + VF + VS);
  endfunction

  task automatic chk_timing(input string tag, input int p);
    chk1({tag, "_de"}, de_out, act_at(p));
    chk1({tag, "_hs"}, hsync_out, hs_at(p));
    chk1({tag, "_vs"}, vsync_out, vs_at(p));
    chk1({tag, "_fs"}, frame_start, (p % (HT * VT)) == 0);
  endtask

  task automatic chk_idle(input string tag);
    chk1({tag, "_de"}, de_out, 1'b0);
    chk1({tag, "_hs"}, hsync_out, 1'b0);
    chk1({tag, "_vs"}, vsync_out, 1'b0);
    chk1({tag, "_fs"}, frame_start, 1'b0);
    chk1({tag, "_req"}, pix_req, 1'b0);
  endtask

  task automatic chk_reset(input string tag);
    chk_idle(tag);
    chk8({tag, "_y"}, y, 8'h10);
    chk8({tag, "_c"}, c, 8'h80);
    chk1({tag, "_uf"}, underflow, 1'b0);
  endtask

  initial begin
    logic uf_m;
    logic ok_pix;
    int   p;

    // Stimulus: enable held, count on pix_y, two starved pixels, a clear, and a clear racing a set.
    for (int i = 0; i < NV; i++) begin
      tbl[i].en    = 1'b1;
      tbl[i].valid = !((i == 131) || (i == 162));
      tbl[i].clr   = (i == 150) || (i == 162);
      tbl[i].py    = 8'(i);
    end
    // Expected: at negedge i the counters sit at position i-1, registered outputs show i-2.
    uf_m = 1'b0;
    for (int i = 0; i < NV; i++) begin
      if (i >= 1) begin
        if (!tbl[i-1].valid && (i >= 2) && act_at(i - 2)) uf_m = 1'b1;
        else if (tbl[i-1].clr)                             uf_m = 1'b0;
      end
      tbl[i].e_uf  = uf_m;
      tbl[i].e_req = (i >= 1) ? act_at(i - 1) : 1'b0;
      if (i < 2) begin
        tbl[i].e_de = 1'b0; tbl[i].e_hs = 1'b0; tbl[i].e_vs = 1'b0; tbl[i].e_fs = 1'b0;
        tbl[i].e_y  = 8'h10; tbl[i].e_c = 8'h80;
      end else begin
        p = i - 2;
        tbl[i].e_de = act_at(p);
        tbl[i].e_hs = hs_at(p);
        tbl[i].e_vs = vs_at(p);
        tbl[i].e_fs = (p % (HT * VT)) == 0;
        ok_pix = act_at(p) && tbl[i-1].valid;
        tbl[i].e_y = ok_pix ? tbl[i-1].py : 8'h10;
        tbl[i].e_c = ok_pix ? (((p % HT) % 2 == 0) ? 8'h40 : 8'hC0) : 8'h80;
      end
    end

    rst_n = 1'b0; enable = 1'b0; pix_valid = 1'b1; clr_underflow = 1'b0;
    pix_y = 8'h00; pix_cb = 8'h40; pix_cr = 8'hC0;
    repeat (2) @(negedge clk);
    chk_reset("por");
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk_idle("idle_wait");
    end

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      chk1("tbl_req", pix_req, tbl[i].e_req);
      chk1("tbl_de", de_out, tbl[i].e_de);
      chk1("tbl_hs", hsync_out, tbl[i].e_hs);
      chk1("tbl_vs", vsync_out, tbl[i].e_vs);
      chk1("tbl_fs", frame_start, tbl[i].e_fs);
      chk1("tbl_uf", underflow, tbl[i].e_uf);
      chk8("tbl_y", y, tbl[i].e_y);
      chk8("tbl_c", c, tbl[i].e_c);
      enable        = tbl[i].en;
      pix_valid     = tbl[i].valid;
      clr_underflow = tbl[i].clr;
      pix_y         = tbl[i].py;
    end

    // Reset while running with underflow set clears everything at once.
    @(negedge clk);
    rst_n = 1'b0; enable = 1'b0; pix_valid = 1'b1; clr_underflow = 1'b0;
    #1 chk_reset("rst_run");
    @(negedge clk);
    rst_n = 1'b1;

    // Restart, then pull reset asynchronously at h=5, v=2 with de_out high.
    @(negedge clk);
    enable = 1'b1;
    for (int k = 1; k <= 38; k++) begin
      @(negedge clk);
      if (k >= 2) chk_timing("pre_rst", k - 2);
      pix_y = 8'(k);
    end
    chk1("pre_rst_de_high", de_out, 1'b1);
    #2 rst_n = 1'b0;
    #1 chk_reset("rst_async");
    enable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk_idle("post_rst");
    end

    // Enable dropped on line 1: the frame drains through h=15, v=7, then stays idle.
    @(negedge clk);
    enable = 1'b1;
    for (int k = 1; k <= 160; k++) begin
      @(negedge clk);
      if (k <= 129) begin
        if (k >= 2) chk_timing("drain", k - 2);
        chk1("drain_req", pix_req, (k <= 128) ? act_at(k - 1) : 1'b0);
      end else begin
        chk_idle("drain_idle");
      end
      if (k == 21) enable = 1'b0;
    end

    // Re-enable: frame_start appears one clock after the first RUN cycle.
    @(negedge clk);
    chk_idle("reen_idle");
    enable = 1'b1;
    @(negedge clk);
    chk1("reen_req", pix_req, 1'b1);
    chk1("reen_fs0", frame_start, 1'b0);
    @(negedge clk);
    chk1("reen_fs1", frame_start, 1'b1);
    chk1("reen_de1", de_out, 1'b1);
    @(negedge clk);
    chk1("reen_fs_end", frame_start, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hdmi_video_timing.md
HDMI_VIDEO_TIMING -- requirements
Module: hdmi_video_timing

Interface
REQ-001 SHALL have parameter H_ACTIVE, 1280, active pixels per line.
REQ-002 SHALL have parameter H_FP, 110, horizontal front porch (clocks).
REQ-003 SHALL have parameter H_SYNC, 40, hsync width (clocks).
REQ-004 SHALL have parameter H_BP, 220, horizontal back porch (clocks).
REQ-005 SHALL have parameter V_ACTIVE, 720, active lines per frame.
REQ-006 SHALL have parameters V_FP 5, V_SYNC 5, V_BP 20: vertical front porch, sync and back porch (lines).
REQ-007 SHALL have parameters HS_POL 1 and VS_POL 1: asserted level of hsync and vsync.
REQ-008 SHALL have port clk, input, 1, pixel clock; one clock; all logic on its rising edge.
REQ-009 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-010 SHALL have port enable, input, 1, run request.
REQ-011 SHALL have ports pix_y, pix_cb, pix_cr, input, 8 each, upstream pixel (first-word-fall-through source).
REQ-012 SHALL have port pix_valid, input, 1, upstream pixel present.
REQ-013 SHALL have port pix_req, output, 1, pixel consumed this cycle.
REQ-014 SHALL have ports y and c, output, 8 each, 4:2:2 luma and chroma to the DDR output stage.
REQ-015 SHALL have ports hsync_out, vsync_out, de_out, output, 1 each, timing to the DDR output stage.
REQ-016 SHALL have ports frame_start and underflow, output, 1 each; and clr_underflow, input, 1.

Function
REQ-017 H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. h_cnt wraps H_TOTAL-1 -> 0 and then increments v_cnt; v_cnt wraps V_TOTAL-1 -> 0.
REQ-018 Region order on both axes: active, front porch, sync, back porch, counting from 0.
REQ-019 FSM states IDLE, RUN, DRAIN; reset state IDLE.
REQ-020 IDLE: counters held at 0, outputs idle; enable=1 -> RUN; the first RUN cycle has h_cnt=0, v_cnt=0.
REQ-021 RUN: counters advance every clock; enable=0 -> DRAIN.
REQ-022 DRAIN: counters advance until the wrap at h=H_TOTAL-1, v=V_TOTAL-1, then IDLE. enable re-asserted during DRAIN -> RUN with no counter disturbance.
REQ-023 act = (h_cnt<H_ACTIVE) & (v_cnt<V_ACTIVE) in RUN or DRAIN; pix_req = act (combinational, same cycle).
REQ-024 Outputs are registered, with 1-clock latency from the counter state: de_out <= act.
REQ-025 hsync_out <= HS_POL while h_cnt is in the H sync region, else ~HS_POL.
REQ-026 vsync_out <= VS_POL while v_cnt is in the V sync region (whole lines), else ~VS_POL.
REQ-027 During act with pix_valid=1: y <= pix_y; c <= pix_cb when h_cnt[0]=0, else pix_cr.
REQ-028 During act with pix_valid=0: y <= 8'h10, c <= 8'h80 (black), and underflow is set.
REQ-029 Outside act: y <= 8'h10, c <= 8'h80.
REQ-030 underflow is sticky; clr_underflow=1 clears it; a set condition in the same cycle as the clear wins.
REQ-031 frame_start <= 1 for exactly one clock, aligned with the output at h=0, v=0, in RUN or DRAIN.
REQ-032 In IDLE: de_out=0, sync outputs inactive, pix_req=0.

Reset
REQ-033 rst_n=0 immediately forces the following:
- state IDLE, counters 0
- de_out=0, hsync_out=~HS_POL, vsync_out=~VS_POL
- y=8'h10, c=8'h80
- frame_start=0, underflow=0
REQ-034 Reset asserted mid-frame abandons the frame; after release, the block waits in IDLE for enable.

Verification (params H 8/2/3/3, V 4/1/2/1: H_TOTAL=16, V_TOTAL=8; polarities 1)
REQ-035 Enable held, pix_valid=1 -> per line 8 de_out clocks, then hsync_out high for 3 clocks starting 10 clocks after de rises; vsync_out high for lines 5-6; frame period 128 clocks; frame_start every 128 clocks.
REQ-036 pix_cb=0x40, pix_cr=0xC0, pix_y=count -> c alternates 0x40/0xC0 starting with 0x40; y equals the pix_y value of the previous clock.
REQ-037 pix_valid=0 for one active clock -> that output is y=0x10, c=0x80 and underflow=1 persists; clr_underflow pulse -> 0; clr coincident with a new underflow -> stays 1.
REQ-038 enable dropped at v=1 -> frame completes through v=7, h=15; then IDLE, de_out stays 0; re-enable -> frame_start 1 clock after the first RUN cycle.
REQ-039 rst_n pulsed low at h=5, v=2 while de_out=1 -> all outputs at reset values asynchronously; after release, no activity until enable.
